instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Immediate/instruction encoder: packs format, register fields, funct3 and a sign-extended immediate into a 32-bit RV64 instruction word.
- Exact inverse of the decode-stage immediate extractor. Any in-range immediate must round-trip bit-exactly through the extractor.
- Used by the instruction-memory loader and self-test sequencer to stream encoded words, with word addresses, into instruction memory.
- Valid/ready on both sides, one registered stage plus a skid entry.

Parameters:
- N, 64, width of the immediate input (matches the extractor output width).
- M, 12, immediate width for I/S/L/B formats.
- MJ, 20, immediate width for J format.
- ADDR_W, 10, width of the word address counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid && ready.
- req_fmt_i  in  3  format code: I=0, S=1, L=2, B=3, J=4; 5..7 invalid.
- req_rd_i  in  5  destination register (I/L/J).
- req_rs1_i  in  5  source register 1 (I/S/L/B).
- req_rs2_i  in  5  source register 2 (S/B).
- req_funct3_i  in  3  funct3 (I/S/L/B).
- req_imm_i  in  N  signed immediate, in the same units the extractor produces.
- base_load_i  in  1  load address counter; only honoured when no output is pending.
- base_addr_i  in  ADDR_W  value for the address counter.
- out_valid_o  out  1  encoded word valid.
- out_ready_i  in  1  consumer ready.
- out_instr_o  out  32  encoded instruction.
- out_addr_o  out  ADDR_W  word address attached to this output.
- out_err_o  out  1  request was rejected (bad format or immediate out of range).
- err_cnt_o  out  8  saturating count of rejected requests.

Behaviour:
- Reset (synchronous, rst_i=1 at a clock edge); next cycle:
  - out_valid_o=0, out_instr_o=0, out_err_o=0, out_addr_o=0, err_cnt_o=0.
  - req_ready_o=1; skid entry emptied.
  - Reset mid-stream discards held entries with no output transfer.
- Field packing. Opcodes: I 0010011, S 0100011, L 0000011, B 1100011, J 1101111.
  - I/L: [31:20]=imm[11:0], [19:15]=rs1, [14:12]=funct3, [11:7]=rd.
  - S: [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=imm[4:0].
  - B: [31]=imm[11], [7]=imm[10], [30:25]=imm[9:4], [11:8]=imm[3:0], rs2/rs1/funct3 as S. The immediate is not shifted; it is the extractor's halfword-unit value.
  - J: [31]=imm[19], [19:12]=imm[18:11], [20]=imm[10], [30:21]=imm[9:0], [11:7]=rd.
- Range check:
  - I/S/L/B: imm[N-1:M-1] all equal.
  - J: imm[N-1:MJ-1] all equal.
  - Failed range check or invalid fmt: out_instr_o=32'h00000013 (NOP), out_err_o=1, err_cnt_o+1 (saturates at 255).
  - A rejected request still consumes an address.
- Latency and throughput:
  - Accepted request appears on out_* the next cycle.
  - Full throughput, one request per cycle, while out_ready_i=1.
- Buffering:
  - Output register plus one skid entry.
  - req_ready_o is registered and equals "skid empty".
  - If the output is stalled and a request is accepted, the request goes to the skid entry; req_ready_o drops the next cycle.
  - When the output transfers, the skid entry (if any) moves to the output and req_ready_o rises the next cycle.
  - Order is strictly preserved; no loss or duplication.
  - out_* must hold stable while out_valid_o && !out_ready_i.
- Address:
  - Counter value is attached to each request at acceptance; counter increments per accepted request and wraps 2^ADDR_W-1 -> 0.
  - base_load_i is applied only if out_valid_o=0 and the skid entry is empty; otherwise it is ignored.
  - If base_load_i and an acceptance occur in the same cycle, the accepted request takes base_addr_i and the counter becomes base_addr_i+1.

Decomposition:
- Shared package: format codes, the five opcode constants, the NOP constant, and the N/M/MJ defaults. The package is shared with the extractor.
- Sub-module instr_enc_skid: generic 2-entry valid/ready skid buffer, parameterised by payload width (32+ADDR_W+1). The encode/range-check logic stays combinational ahead of it.

Test Plan:
- I, rd=1, rs1=2, funct3=0, imm=all ones (-1) -> one cycle later out_instr_o=0xFFF10093, out_err_o=0, out_addr_o=0.
- S, rs1=2, rs2=5, funct3=3, imm=8 -> 0x00513423, out_addr_o=1.
- J, rd=1, imm=1 -> 0x002000EF. Also 1000 random in-range immediates per format fed to the extractor model -> returned value equals imm.
- B, imm=2048; then fmt=6 -> both give 0x00000013 with out_err_o=1, err_cnt_o=2, addresses still advance.
- 4 back-to-back requests with out_ready_i=0 for 3 cycles -> 2 accepted, req_ready_o=0 until release, outputs emitted in order, addresses sequential, stable while stalled.
- base_load_i=1, base_addr_i=1023 while idle, then 2 requests -> addresses 1023 then 0 (wrap). rst_i with both entries full -> next cycle out_valid_o=0, req_ready_o=1, err_cnt_o=0.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder and the decode-stage immediate extractor.
// Holds the format codes, the base opcodes for each format, the canonical NOP word and the
// default immediate widths.
package instr_encoder_pkg;

   // Default widths: extractor output, short (I/S/L/B) immediate, J immediate.
   localparam int unsigned DefN  = 64;
   localparam int unsigned DefM  = 12;
   localparam int unsigned DefMJ = 20;

   // Request format codes; 5..7 are reserved and rejected.
   typedef enum logic [2:0] {
      FmtI = 3'd0,
      FmtS = 3'd1,
      FmtL = 3'd2,
      FmtB = 3'd3,
      FmtJ = 3'd4
   } fmt_e;

   localparam logic [6:0] OpcI = 7'b0010011;
   localparam logic [6:0] OpcS = 7'b0100011;
   localparam logic [6:0] OpcL = 7'b0000011;
   localparam logic [6:0] OpcB = 7'b1100011;
   localparam logic [6:0] OpcJ = 7'b1101111;

   // addi x0, x0, 0
   localparam logic [31:0] InstrNop = 32'h0000_0013;

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bundle of the instruction encoder.
//   req_*  : encode request (valid/ready), format, register fields, funct3, signed immediate
//   out_*  : encoded word (valid/ready), attached word address, reject flag
// master = request producer / word consumer, slave = encoder.
interface instr_encoder_if
   import instr_encoder_pkg::*;
#(
   parameter int unsigned N      = DefN,
   parameter int unsigned ADDR_W = 10
);
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_fmt;
   logic [4:0]        req_rd;
   logic [4:0]        req_rs1;
   logic [4:0]        req_rs2;
   logic [2:0]        req_funct3;
   logic [N-1:0]      req_imm;

   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [ADDR_W-1:0] out_addr;
   logic              out_err;

   modport master (
      output req_valid, req_fmt, req_rd, req_rs1, req_rs2, req_funct3, req_imm, out_ready,
      input  req_ready, out_valid, out_instr, out_addr, out_err
   );

   modport slave (
      input  req_valid, req_fmt, req_rd, req_rs1, req_rs2, req_funct3, req_imm, out_ready,
      output req_ready, out_valid, out_instr, out_addr, out_err
   );

endinterface

// File: rtl/instr_enc_skid.sv
// Two-entry valid/ready buffer: an output register plus one skid entry.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   in_valid_i/in_ready_o  : upstream handshake; in_ready_o is registered ("skid empty")
//   in_data_i              : upstream payload
//   out_valid_o/out_ready_i: downstream handshake
//   out_data_o             : downstream payload, held stable while stalled
module instr_enc_skid #(
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [Width-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [Width-1:0] out_data_o
);

   logic             out_valid_q, out_valid_d;
   logic [Width-1:0] out_data_q, out_data_d;
   logic             skid_valid_q, skid_valid_d;
   logic [Width-1:0] skid_data_q, skid_data_d;
   logic             ready_q;
   logic             in_fire;

   assign in_fire = in_valid_i & ready_q;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (!out_valid_q || out_ready_i) begin
         // Output slot frees up: the skid entry is older, so it goes first. ready_q is low
         // whenever the skid is occupied, so no new request can arrive in that case.
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = in_fire;
            if (in_fire) begin
               out_data_d = in_data_i;
            end
         end
      end else if (in_fire) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         ready_q      <= 1'b1;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         ready_q      <= ~skid_valid_d;
      end
   end

   assign in_ready_o  = ready_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs format, registers, funct3 and a signed immediate into a 32-bit
// RV64 word and attaches a running word address. Inverse of the decode-stage extractor.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   bus (slave)   : request in, encoded word / address / reject flag out
//   base_load_i   : load the address counter (only when nothing is buffered)
//   base_addr_i   : value loaded into the address counter
//   err_cnt_o     : saturating count of rejected requests
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int unsigned N      = DefN,
   parameter int unsigned M      = DefM,
   parameter int unsigned MJ     = DefMJ,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   instr_encoder_if.slave    bus,
   input  logic              base_load_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   output logic [7:0]        err_cnt_o
);

   localparam int unsigned PayW = 32 + ADDR_W + 1;

   logic [N-1:0]      imm;
   logic [31:0]       enc;
   logic [31:0]       word;
   logic              fmt_ok, rng_ok, short_ok, long_ok, err;
   logic              in_fire, load_ok;
   logic [ADDR_W-1:0] addr_q, addr_d, acc_addr;
   logic [7:0]        err_cnt_q, err_cnt_d;
   logic [PayW-1:0]   pay_in, pay_out;

   assign imm = bus.req_imm;

   // In range when every bit from the top down to the field's sign bit agrees.
   assign short_ok = (&imm[N-1:M-1])  | ~(|imm[N-1:M-1]);
   assign long_ok  = (&imm[N-1:MJ-1]) | ~(|imm[N-1:MJ-1]);

   always_comb begin
      enc    = InstrNop;
      fmt_ok = 1'b1;
      rng_ok = short_ok;
      case (bus.req_fmt)
         FmtI: enc = {imm[11:0], bus.req_rs1, bus.req_funct3, bus.req_rd, OpcI};
         FmtL: enc = {imm[11:0], bus.req_rs1, bus.req_funct3, bus.req_rd, OpcL};
         FmtS: enc = {imm[11:5], bus.req_rs2, bus.req_rs1, bus.req_funct3, imm[4:0], OpcS};
         // imm is already in halfword units, so bit 0 of the value lands in instr[8].
         FmtB: enc = {imm[11], imm[9:4], bus.req_rs2, bus.req_rs1, bus.req_funct3,
                      imm[3:0], imm[10], OpcB};
         FmtJ: begin
            enc    = {imm[19], imm[9:0], imm[10], imm[18:11], bus.req_rd, OpcJ};
            rng_ok = long_ok;
         end
         default: fmt_ok = 1'b0;
      endcase
   end

   assign err  = ~(fmt_ok & rng_ok);
   assign word = err ? InstrNop : enc;

   // Address counter; a base load is only safe when no word is waiting with an old address.
   assign in_fire  = bus.req_valid & bus.req_ready;
   assign load_ok  = base_load_i & ~bus.out_valid & bus.req_ready;
   assign acc_addr = load_ok ? base_addr_i : addr_q;

   always_comb begin
      addr_d    = addr_q;
      err_cnt_d = err_cnt_q;
      if (in_fire) begin
         addr_d = acc_addr + ADDR_W'(1);
         if (err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
      end else if (load_ok) begin
         addr_d = base_addr_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_q    <= '0;
         err_cnt_q <= '0;
      end else begin
         addr_q    <= addr_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign pay_in = {word, acc_addr, err};

   instr_enc_skid #(
      .Width (PayW)
   ) u_skid (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (bus.req_valid),
      .in_ready_o  (bus.req_ready),
      .in_data_i   (pay_in),
      .out_valid_o (bus.out_valid),
      .out_ready_i (bus.out_ready),
      .out_data_o  (pay_out)
   );

   assign bus.out_instr = pay_out[PayW-1 -: 32];
   assign bus.out_addr  = pay_out[ADDR_W:1];
   assign bus.out_err   = pay_out[0];
   assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed packing/error/stall/address/reset cases and
// a randomized stream whose outputs are decoded by a reference extractor and compared with the
// original requests.
module tb_instr_encoder;
   import instr_encoder_pkg::*;

   localparam int unsigned AW = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          base_load = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [7:0]    err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   instr_encoder_if #(.N(64), .ADDR_W(AW)) bus ();

   instr_encoder #(
      .N      (64),
      .M      (12),
      .MJ     (20),
      .ADDR_W (AW)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .bus         (bus),
      .base_load_i (base_load),
      .base_addr_i (base_addr),
      .err_cnt_o   (err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]    fmt;
      logic [4:0]    rd, rs1, rs2;
      logic [2:0]    f3;
      longint        imm;
      logic          err;
      logic [AW-1:0] addr;
   } exp_t;

   exp_t sb[$];
   bit   drv_done;
   int   n_err_model;

   // ---------------- reference model (spec-level) ----------------
   function automatic longint imm_lim(input logic [2:0] fmt);
      return (fmt == 3'd4) ? (longint'(1) <<< 19) : (longint'(1) <<< 11);
   endfunction

   function automatic bit accepted_ok(input logic [2:0] fmt, input longint imm);
      if (fmt > 3'd4) return 1'b0;
      return (imm >= -imm_lim(fmt)) && (imm < imm_lim(fmt));
   endfunction

   // Decode-stage immediate extractor.
   function automatic longint extract(input logic [2:0] fmt, input logic [31:0] w);
      logic signed [11:0] s12;
      logic signed [19:0] s20;
      case (fmt)
         3'd1:    s12 = {w[31:25], w[11:7]};
         3'd3:    s12 = {w[31], w[7], w[30:25], w[11:8]};
         default: s12 = w[31:20];
      endcase
      s20 = {w[31], w[19:12], w[20], w[30:21]};
      return (fmt == 3'd4) ? longint'(s20) : longint'(s12);
   endfunction

   function automatic logic [6:0] opcode_of(input logic [2:0] fmt);
      case (fmt)
         3'd0:    return 7'b0010011;
         3'd1:    return 7'b0100011;
         3'd2:    return 7'b0000011;
         3'd3:    return 7'b1100011;
         default: return 7'b1101111;
      endcase
   endfunction

   // {opcode, rd, rs1, rs2, funct3}, with fields the format does not carry forced to zero.
   function automatic logic [24:0] fields_exp(input exp_t e);
      bit u_rd  = (e.fmt == 3'd0) || (e.fmt == 3'd2) || (e.fmt == 3'd4);
      bit u_rs1 = (e.fmt <= 3'd3);
      bit u_rs2 = (e.fmt == 3'd1) || (e.fmt == 3'd3);
      return {opcode_of(e.fmt), u_rd ? e.rd : 5'd0, u_rs1 ? e.rs1 : 5'd0,
              u_rs2 ? e.rs2 : 5'd0, u_rs1 ? e.f3 : 3'd0};
   endfunction

   function automatic logic [24:0] fields_got(input logic [2:0] fmt, input logic [31:0] w);
      bit u_rd  = (fmt == 3'd0) || (fmt == 3'd2) || (fmt == 3'd4);
      bit u_rs1 = (fmt <= 3'd3);
      bit u_rs2 = (fmt == 3'd1) || (fmt == 3'd3);
      return {w[6:0], u_rd ? w[11:7] : 5'd0, u_rs1 ? w[19:15] : 5'd0,
              u_rs2 ? w[24:20] : 5'd0, u_rs1 ? w[14:12] : 3'd0};
   endfunction

   // addi xk, x0, k
   function automatic logic [31:0] addi_word(input int k);
      return 32'((k << 20) + (k << 7) + 'h13);
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [2:0] f3, input longint imm);
      bus.req_fmt    = fmt;
      bus.req_rd     = rd;
      bus.req_rs1    = rs1;
      bus.req_rs2    = rs2;
      bus.req_funct3 = f3;
      bus.req_imm    = imm;
      bus.req_valid  = 1'b1;
   endtask

   task automatic idle_req();
      set_req(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 0);
      bus.req_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      base_load = 1'b0;
      idle_req();
      tick();
      rst = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      bus.out_ready = 1'b0;
      idle_req();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++;
         $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      n_checks++; if (bus.out_instr !== 32'h0) begin n_fail++;
         $display("FAIL reset_out_instr: got %h want 00000000", bus.out_instr); end
      n_checks++; if (bus.out_err !== 1'b0) begin n_fail++;
         $display("FAIL reset_out_err: got %b want 0", bus.out_err); end
      n_checks++; if (bus.out_addr !== '0) begin n_fail++;
         $display("FAIL reset_out_addr: got %0d want 0", bus.out_addr); end
      n_checks++; if (err_cnt !== 8'd0) begin n_fail++;
         $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
      n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++;
         $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
   endtask

   task automatic test_packing();
      bus.out_ready = 1'b1;
      set_req(3'd0, 5'd1, 5'd2, 5'd0, 3'd0, -1);
      tick();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hFFF10093) begin n_fail++;
         $display("FAIL pack_i: got v=%b %h want v=1 fff10093", bus.out_valid, bus.out_instr); end
      n_checks++; if (bus.out_err !== 1'b0 || bus.out_addr !== 10'd0) begin n_fail++;
         $display("FAIL pack_i_meta: got err=%b addr=%0d want 0/0", bus.out_err, bus.out_addr); end
      set_req(3'd1, 5'd0, 5'd2, 5'd5, 3'd3, 8);
      tick();
      n_checks++; if (bus.out_instr !== 32'h00513423) begin n_fail++;
         $display("FAIL pack_s: got %h want 00513423", bus.out_instr); end
      n_checks++; if (bus.out_err !== 1'b0 || bus.out_addr !== 10'd1) begin n_fail++;
         $display("FAIL pack_s_meta: got err=%b addr=%0d want 0/1", bus.out_err, bus.out_addr); end
      set_req(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1);
      tick();
      n_checks++; if (bus.out_instr !== 32'h002000EF || bus.out_addr !== 10'd2) begin n_fail++;
         $display("FAIL pack_j: got %h addr=%0d want 002000ef addr=2", bus.out_instr,
                  bus.out_addr); end
   endtask

   task automatic test_errors();
      set_req(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 2048);
      tick();
      n_checks++; if (bus.out_instr !== 32'h13 || bus.out_err !== 1'b1) begin n_fail++;
         $display("FAIL err_b_range: got %h err=%b want 00000013 err=1", bus.out_instr,
                  bus.out_err); end
      n_checks++; if (bus.out_addr !== 10'd3 || err_cnt !== 8'd1) begin n_fail++;
         $display("FAIL err_b_meta: got addr=%0d cnt=%0d want 3/1", bus.out_addr, err_cnt); end
      set_req(3'd6, 5'd0, 5'd0, 5'd0, 3'd0, 0);
      tick();
      n_checks++; if (bus.out_instr !== 32'h13 || bus.out_err !== 1'b1) begin n_fail++;
         $display("FAIL err_fmt: got %h err=%b want 00000013 err=1", bus.out_instr,
                  bus.out_err); end
      n_checks++; if (bus.out_addr !== 10'd4 || err_cnt !== 8'd2) begin n_fail++;
         $display("FAIL err_fmt_meta: got addr=%0d cnt=%0d want 4/2", bus.out_addr, err_cnt); end
      idle_req();
      tick();
   endtask

   task automatic test_back_to_back();
      do_reset();
      bus.out_ready = 1'b0;
      set_req(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 1);
      tick();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.req_ready !== 1'b1) begin n_fail++;
         $display("FAIL b2b_first: got v=%b rdy=%b want 1/1", bus.out_valid, bus.req_ready); end
      set_req(3'd0, 5'd2, 5'd0, 5'd0, 3'd0, 2);
      tick();
      n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++;
         $display("FAIL b2b_skid_full: got rdy=%b want 0", bus.req_ready); end
      set_req(3'd0, 5'd3, 5'd0, 5'd0, 3'd0, 3);
      tick();
      n_checks++; if (bus.req_ready !== 1'b0 || bus.out_valid !== 1'b1) begin n_fail++;
         $display("FAIL b2b_stall: got rdy=%b v=%b want 0/1", bus.req_ready, bus.out_valid); end
      n_checks++; if (bus.out_instr !== addi_word(1) || bus.out_addr !== 10'd0) begin n_fail++;
         $display("FAIL b2b_hold: got %h addr=%0d want %h addr=0", bus.out_instr, bus.out_addr,
                  addi_word(1)); end
      bus.out_ready = 1'b1;
      tick();
      n_checks++; if (bus.out_instr !== addi_word(2) || bus.out_addr !== 10'd1) begin n_fail++;
         $display("FAIL b2b_out2: got %h addr=%0d want %h addr=1", bus.out_instr, bus.out_addr,
                  addi_word(2)); end
      n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++;
         $display("FAIL b2b_ready_back: got %b want 1", bus.req_ready); end
      tick();
      n_checks++; if (bus.out_instr !== addi_word(3) || bus.out_addr !== 10'd2) begin n_fail++;
         $display("FAIL b2b_out3: got %h addr=%0d want %h addr=2", bus.out_instr, bus.out_addr,
                  addi_word(3)); end
      set_req(3'd0, 5'd4, 5'd0, 5'd0, 3'd0, 4);
      tick();
      n_checks++; if (bus.out_instr !== addi_word(4) || bus.out_addr !== 10'd3) begin n_fail++;
         $display("FAIL b2b_out4: got %h addr=%0d want %h addr=3", bus.out_instr, bus.out_addr,
                  addi_word(4)); end
      idle_req();
      tick();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++;
         $display("FAIL b2b_drain: got v=%b want 0", bus.out_valid); end
   endtask

   task automatic test_base_addr();
      do_reset();
      bus.out_ready = 1'b1;
      base_load = 1'b1;
      base_addr = 10'd1023;
      tick();
      base_load = 1'b0;
      set_req(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 1);
      tick();
      n_checks++; if (bus.out_addr !== 10'd1023) begin n_fail++;
         $display("FAIL base_load: got %0d want 1023", bus.out_addr); end
      set_req(3'd0, 5'd2, 5'd0, 5'd0, 3'd0, 2);
      tick();
      n_checks++; if (bus.out_addr !== 10'd0) begin n_fail++;
         $display("FAIL base_wrap: got %0d want 0", bus.out_addr); end
      idle_req();
      tick();
      // Load and accept in the same cycle.
      base_load = 1'b1;
      base_addr = 10'd500;
      set_req(3'd0, 5'd3, 5'd0, 5'd0, 3'd0, 3);
      tick();
      base_load = 1'b0;
      n_checks++; if (bus.out_addr !== 10'd500) begin n_fail++;
         $display("FAIL base_same_cycle: got %0d want 500", bus.out_addr); end
      set_req(3'd0, 5'd4, 5'd0, 5'd0, 3'd0, 4);
      tick();
      n_checks++; if (bus.out_addr !== 10'd501) begin n_fail++;
         $display("FAIL base_after_load: got %0d want 501", bus.out_addr); end
      // Load attempted while a word is pending must be ignored.
      idle_req();
      bus.out_ready = 1'b0;
      base_load = 1'b1;
      base_addr = 10'd7;
      tick();
      base_load = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      set_req(3'd0, 5'd5, 5'd0, 5'd0, 3'd0, 5);
      tick();
      n_checks++; if (bus.out_addr !== 10'd502) begin n_fail++;
         $display("FAIL base_ignored: got %0d want 502", bus.out_addr); end
      idle_req();
      tick();
   endtask

   task automatic test_reset_midstream();
      bus.out_ready = 1'b0;
      set_req(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 0);
      tick();
      set_req(3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 0);
      tick();
      n_checks++; if (bus.req_ready !== 1'b0 || err_cnt === 8'd0) begin n_fail++;
         $display("FAIL mid_full: got rdy=%b cnt=%0d want 0/nonzero", bus.req_ready, err_cnt); end
      idle_req();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (bus.out_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++;
         $display("FAIL mid_reset: got v=%b rdy=%b want 0/1", bus.out_valid, bus.req_ready); end
      n_checks++; if (err_cnt !== 8'd0 || bus.out_addr !== '0) begin n_fail++;
         $display("FAIL mid_reset_cnt: got cnt=%0d addr=%0d want 0/0", err_cnt, bus.out_addr); end
      bus.out_ready = 1'b1;
      tick();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++;
         $display("FAIL mid_no_leftover: got v=%b want 0", bus.out_valid); end
   endtask

   task automatic drive_random(input int total);
      int exp_addr = 0;
      for (int i = 0; i < total; i++) begin
         exp_t   e;
         longint lim;
         bit     rdy;
         int     w;
         e.rd  = 5'($urandom);
         e.rs1 = 5'($urandom);
         e.rs2 = 5'($urandom);
         e.f3  = 3'($urandom);
         if ((i % 6) < 5) begin
            e.fmt = 3'(i % 6);
            lim   = imm_lim(e.fmt);
            case ($urandom_range(0, 15))
               0:       e.imm = lim - 1;
               1:       e.imm = -lim;
               default: e.imm = longint'($urandom_range(0, 32'(2 * lim - 1))) - lim;
            endcase
         end else if ($urandom_range(0, 2) == 0) begin
            e.fmt = 3'(5 + $urandom_range(0, 2));
            e.imm = longint'({$urandom, $urandom});
         end else begin
            e.fmt = 3'($urandom_range(0, 4));
            lim   = imm_lim(e.fmt);
            case ($urandom_range(0, 2))
               0:       e.imm = lim;
               1:       e.imm = -lim - 1;
               default: e.imm = longint'({$urandom, $urandom});
            endcase
         end
         e.err  = !accepted_ok(e.fmt, e.imm);
         e.addr = AW'(exp_addr);
         if ($urandom_range(0, 7) == 0) begin
            bus.req_valid = 1'b0;
            tick();
         end
         set_req(e.fmt, e.rd, e.rs1, e.rs2, e.f3, e.imm);
         w = 0;
         do begin
            rdy = bus.req_ready;
            tick();
            w++;
         end while (!rdy && w < 1000);
         if (!rdy) begin
            n_checks++; n_fail++;
            $display("FAIL rand_accept_timeout: got no acceptance want acceptance, item %0d", i);
            break;
         end
         sb.push_back(e);
         exp_addr    = (exp_addr + 1) % (1 << AW);
         n_err_model = n_err_model + int'(e.err);
      end
      bus.req_valid = 1'b0;
      drv_done = 1'b1;
   endtask

   task automatic monitor_random();
      logic          pv, pr, perr;
      logic [31:0]   pinstr;
      logic [AW-1:0] paddr;
      exp_t          e;
      for (int cyc = 0; cyc < 60000; cyc++) begin
         if (drv_done && sb.size() == 0) break;
         bus.out_ready = ($urandom_range(0, 9) < 7);
         pv = bus.out_valid; pr = bus.out_ready;
         pinstr = bus.out_instr; paddr = bus.out_addr; perr = bus.out_err;
         tick();
         if (pv && pr) begin
            if (sb.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL rand_extra_output: got %h want nothing", pinstr);
            end else begin
               e = sb.pop_front();
               n_checks++; if (perr !== e.err) begin n_fail++;
                  $display("FAIL rand_err: got %b want %b fmt=%0d imm=%0d", perr, e.err, e.fmt,
                           e.imm); end
               n_checks++; if (paddr !== e.addr) begin n_fail++;
                  $display("FAIL rand_addr: got %0d want %0d", paddr, e.addr); end
               if (e.err) begin
                  n_checks++; if (pinstr !== 32'h13) begin n_fail++;
                     $display("FAIL rand_nop: got %h want 00000013", pinstr); end
               end else begin
                  n_checks++; if (extract(e.fmt, pinstr) !== e.imm) begin n_fail++;
                     $display("FAIL rand_roundtrip: got %0d want %0d fmt=%0d word=%h",
                              extract(e.fmt, pinstr), e.imm, e.fmt, pinstr); end
                  n_checks++; if (fields_got(e.fmt, pinstr) !== fields_exp(e)) begin n_fail++;
                     $display("FAIL rand_fields: got %h want %h fmt=%0d", fields_got(e.fmt,
                              pinstr), fields_exp(e), e.fmt); end
               end
            end
         end else if (pv) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || {bus.out_instr, bus.out_addr, bus.out_err} !==
                {pinstr, paddr, perr}) begin
               n_fail++;
               $display("FAIL rand_stable: got v=%b %h/%0d/%b want 1 %h/%0d/%b", bus.out_valid,
                        bus.out_instr, bus.out_addr, bus.out_err, pinstr, paddr, perr);
            end
         end
      end
      if (!(drv_done && sb.size() == 0)) begin
         n_checks++; n_fail++;
         $display("FAIL rand_drain_timeout: got %0d pending want 0", sb.size());
      end
   endtask

   task automatic test_random();
      do_reset();
      drv_done    = 1'b0;
      n_err_model = 0;
      fork
         drive_random(6000);
         monitor_random();
      join
      bus.out_ready = 1'b1;
      tick();
      n_checks++;
      if (int'(err_cnt) != ((n_err_model > 255) ? 255 : n_err_model)) begin
         n_fail++;
         $display("FAIL rand_err_cnt: got %0d want %0d", err_cnt,
                  (n_err_model > 255) ? 255 : n_err_model);
      end
   endtask

   initial begin
      test_reset();
      test_packing();
      test_errors();
      test_back_to_back();
      test_base_addr();
      test_reset_midstream();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
